// File: rtl/core_pkg.sv
// Shared types and constants for the integer-core instruction sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_RSP = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WB       = 3'd4,
    S_TRAP     = 3'd5
  } seq_state_e;

  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [6:0]  OPC_OP     = 7'h33;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          PC_STEP    = 4;

  function automatic logic is_alu_opc(input logic [6:0] opc);
    return (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns pc and ir, runs the
// instruction-memory and ALU handshakes, and parks in a sticky TRAP on faults.
module instr_seq_ctrl
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              ALU_TMO  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     ir,
  output logic            alu_src_imm,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] pc,
  output logic            trap,
  output logic            retired
);

  localparam int CW = $clog2(ALU_TMO + 1);

  seq_state_e      state, state_nxt;
  logic [CW-1:0]   exec_cnt;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic            src_imm_q;
  logic            exec_first, exec_last;

  assign exec_first = (exec_cnt == '0);
  assign exec_last  = (exec_cnt == CW'(ALU_TMO - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (imem_req_ready) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: if (imem_rsp_valid) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = is_alu_opc(ir_q[6:0]) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        // done coincident with the start pulse belongs to no live operation
        if (!exec_first && alu_done) state_nxt = S_WB;
        else if (exec_last)          state_nxt = S_TRAP;
      end
      S_WB:       state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSN;
      src_imm_q <= 1'b1;
      exec_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT_RSP && imem_rsp_valid) begin
        ir_q      <= imem_rsp_data;
        src_imm_q <= (imem_rsp_data[6:0] == OPC_OP_IMM);
      end
      exec_cnt <= (state == S_EXEC) ? exec_cnt + 1'b1 : '0;
      if (state == S_WB) pc_q <= pc_q + XLEN'(PC_STEP);
    end
  end

  // Handshake strobes are masked while reset is held so a core caught mid-flight
  // never emits a request, start or write in the reset cycle.
  assign imem_req_valid = rst_n && (state == S_FETCH);
  assign alu_start      = rst_n && (state == S_EXEC) && exec_first;
  assign retired        = rst_n && (state == S_WB);
  assign rf_we          = rst_n && (state == S_WB) && (ir_q[11:7] != 5'd0);
  assign trap           = (state == S_TRAP);

  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign ir             = ir_q;
  assign rf_waddr       = ir_q[11:7];
  assign alu_src_imm    = src_imm_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Randomized bench: a timeline model expands each instruction into per-cycle
// stimulus and expected outputs; two instances differ only in RESET_PC.
module tb_instr_seq_ctrl;
  import core_pkg::*;

  localparam int          TMO   = 16;
  localparam logic [31:0] RPC_A = 32'h0;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst_n = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, alu_done = 1'b0;
  logic [31:0] imem_rsp_data = '0;

  logic a_req_valid, a_src, a_start, a_we, a_trap, a_ret;
  logic [31:0] a_addr, a_ir, a_pc;
  logic [4:0]  a_waddr;
  logic b_req_valid, b_src, b_start, b_we, b_trap, b_ret;
  logic [31:0] b_addr, b_ir, b_pc;
  logic [4:0]  b_waddr;

  always #5 clk = ~clk;

  instr_seq_ctrl #(.XLEN(32), .RESET_PC(RPC_A), .ALU_TMO(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ir(a_ir), .alu_src_imm(a_src), .alu_start(a_start), .alu_done(alu_done),
    .rf_we(a_we), .rf_waddr(a_waddr), .pc(a_pc), .trap(a_trap), .retired(a_ret));

  instr_seq_ctrl #(.XLEN(32), .RESET_PC(RPC_B), .ALU_TMO(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(b_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ir(b_ir), .alu_src_imm(b_src), .alu_start(b_start), .alu_done(alu_done),
    .rf_we(b_we), .rf_waddr(b_waddr), .pc(b_pc), .trap(b_trap), .retired(b_ret));

  // One cycle of stimulus plus what the outputs must be during that cycle.
  typedef struct {
    logic        rst_n, rdy, rv, done;
    logic [31:0] rd;
    logic        e_req, e_start, e_we, e_ret, e_trap, e_src;
    logic        chk_st, chk_ir, chk_src;
    logic [31:0] e_ir, e_pc;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  event do_chk;
  int tests = 0, fails = 0;
  int seg_cyc, ret_cyc, we_cnt;
  logic [4:0] last_waddr;

  // architectural model: pc as offset from RESET_PC, current ir, trapped flag
  logic [31:0] m_pc, m_ir;
  logic        m_trap;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.rst_n = 1'b1; v.rdy = 1'($urandom); v.rv = 1'($urandom); v.done = 1'($urandom);
    v.rd = $urandom;
    v.e_req = 0; v.e_start = 0; v.e_we = 0; v.e_ret = 0; v.e_trap = m_trap; v.e_src = 0;
    v.chk_st = 1; v.chk_ir = 1; v.chk_src = 0;
    v.e_ir = m_ir; v.e_pc = m_pc;
    return v;
  endfunction

  task automatic add_reset(input int n);
    vec_t v;
    for (int c = 0; c < n; c++) begin
      v = blank();
      v.rst_n = 1'b0; v.e_trap = 1'b0;
      v.chk_st = (c > 0); v.chk_ir = (c > 0);
      v.e_pc = '0; v.e_ir = NOP_INSN;
      vq.push_back(v);
    end
    m_pc = '0; m_ir = NOP_INSN; m_trap = 1'b0;
  endtask

  task automatic add_trap(input int n);
    for (int c = 0; c < n; c++) vq.push_back(blank());
  endtask

  // r: wait cycles before ready, s: before rsp, d: EXEC index of alu_done,
  // spur: stray rsp on the ready cycle and stray done on the start cycle,
  // rst_at: EXEC index at which reset is asserted (-1 for none)
  task automatic add_insn(input logic [31:0] insn, input int r, input int s, input int d,
                          input bit spur, input int rst_at);
    vec_t v;
    logic imm;
    imm = (insn[6:0] == 7'h13);
    for (int i = 0; i <= r; i++) begin
      v = blank(); v.rdy = (i == r); v.e_req = 1'b1;
      if (i == r && spur) v.rv = 1'b1;
      vq.push_back(v);
    end
    for (int j = 0; j <= s; j++) begin
      v = blank(); v.rv = (j == s);
      if (j == s) v.rd = insn;
      vq.push_back(v);
    end
    m_ir = insn;
    vq.push_back(blank());
    if (insn[6:0] != 7'h13 && insn[6:0] != 7'h33) begin
      m_trap = 1'b1;
      return;
    end
    for (int k = 0; k < TMO; k++) begin
      if (k == rst_at) begin
        add_reset(2);
        return;
      end
      v = blank();
      v.done = (k == d) || (k == 0 && spur);
      v.e_start = (k == 0); v.chk_src = 1'b1; v.e_src = imm;
      vq.push_back(v);
      if (k > 0 && k == d) break;
      if (k == TMO - 1) begin
        m_trap = 1'b1;
        return;
      end
    end
    v = blank();
    v.e_we = (insn[11:7] != 5'd0); v.e_ret = 1'b1; v.chk_src = 1'b1; v.e_src = imm;
    vq.push_back(v);
    m_pc = m_pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33;
    return w;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] w;
    w = $urandom;
    while (w[6:0] == 7'h13 || w[6:0] == 7'h33) w[6:0] = 7'($urandom);
    return w;
  endfunction

  // Driver sits on a negedge, applies one vector, then advances one cycle.
  task automatic run();
    vec_t v;
    seg_cyc = 0; ret_cyc = 0; we_cnt = 0;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      rst_n = v.rst_n; imem_req_ready = v.rdy; imem_rsp_valid = v.rv;
      imem_rsp_data = v.rd; alu_done = v.done;
      cur = v;
      ->do_chk;
      @(negedge clk);
    end
  endtask

  initial begin
    forever begin
      @(do_chk);
      #2;
      seg_cyc++;
      chk1("req_valid", a_req_valid, cur.e_req);
      chk1("b_req_valid", b_req_valid, cur.e_req);
      if (cur.e_req) begin
        chk32("req_addr", a_addr, RPC_A + cur.e_pc);
        chk32("b_req_addr", b_addr, RPC_B + cur.e_pc);
      end
      chk1("alu_start", a_start, cur.e_start);
      chk1("rf_we", a_we, cur.e_we);
      chk1("retired", a_ret, cur.e_ret);
      chk1("b_retired", b_ret, cur.e_ret);
      if (cur.chk_st) begin
        chk1("trap", a_trap, cur.e_trap);
        chk1("b_trap", b_trap, cur.e_trap);
        chk32("pc", a_pc, RPC_A + cur.e_pc);
        chk32("b_pc", b_pc, RPC_B + cur.e_pc);
      end
      if (cur.chk_ir) begin
        chk32("ir", a_ir, cur.e_ir);
        chk32("rf_waddr", 32'(a_waddr), 32'(cur.e_ir[11:7]));
      end
      if (cur.chk_src) chk1("alu_src_imm", a_src, cur.e_src);
      if (a_we) begin
        we_cnt++;
        last_waddr = a_waddr;
      end
      if (a_ret) ret_cyc = seg_cyc;
    end
  end

  initial begin
    logic [31:0] pc_hold;
    m_pc = '0; m_ir = NOP_INSN; m_trap = 1'b0;
    @(negedge clk);

    add_reset(3); run();
    chk32("rst_pc", a_pc, 32'h0);
    chk32("rst_ir", a_ir, 32'h13);
    chk1("rst_trap", a_trap, 1'b0);
    rst_n = 1'b1; #1;
    chk1("rel_req_valid", a_req_valid, 1'b1);

    add_insn(32'h0050_0093, 0, 0, 1, 1'b0, -1); run();
    chk32("addi_retire_cycle", 32'(ret_cyc), 32'd6);
    chk32("addi_we_cnt", 32'(we_cnt), 32'd1);
    chk32("addi_waddr", 32'(last_waddr), 32'd1);
    chk1("addi_src_imm", a_src, 1'b1);
    chk32("addi_pc", a_pc, 32'h4);
    chk32("wrap_pc", b_pc, 32'h0);

    add_insn(32'h0020_81B3, 3, 0, 4, 1'b0, -1); run();
    chk32("add_we_cnt", 32'(we_cnt), 32'd1);
    chk32("add_waddr", 32'(last_waddr), 32'd3);
    chk1("add_src_imm", a_src, 1'b0);
    chk32("add_pc", a_pc, 32'h8);

    add_insn(32'h0000_0013, 0, 0, 1, 1'b0, -1); run();
    chk32("nop_we_cnt", 32'(we_cnt), 32'd0);
    chk32("nop_retire_cycle", 32'(ret_cyc), 32'd6);
    chk32("nop_pc", a_pc, 32'hC);

    add_insn(32'h0000_0093, 1, 1, TMO - 1, 1'b1, -1); run();
    chk32("late_done_we_cnt", 32'(we_cnt), 32'd1);

    for (int n = 0; n < 40; n++)
      add_insn(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(1, 5), 1'($urandom), -1);
    run();
    chk32("burst_pc", a_pc, 32'd16 + 32'd160);

    pc_hold = a_pc;
    add_insn(32'h0000_007F, 1, 0, 1, 1'b0, -1); add_trap(8); run();
    chk1("illegal_trap", a_trap, 1'b1);
    chk32("illegal_pc", a_pc, pc_hold);
    chk32("illegal_we_cnt", 32'(we_cnt), 32'd0);
    add_reset(2); run();

    add_insn(32'h0000_0093, 0, 0, TMO, 1'b0, -1); add_trap(4); run();
    chk1("tmo_trap", a_trap, 1'b1);
    chk32("tmo_we_cnt", 32'(we_cnt), 32'd0);
    add_reset(2); run();

    add_insn(32'h0000_0093, 0, 0, 1, 1'b0, -1);
    add_insn(32'h0030_8093, 0, 0, 5, 1'b0, 2); run();
    chk32("rst_exec_we_cnt", 32'(we_cnt), 32'd1);
    chk32("rst_exec_pc", a_pc, 32'h0);
    chk1("rst_exec_trap", a_trap, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if (m_trap) begin
        add_trap($urandom_range(1, 4));
        add_reset($urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 9))
          0: add_insn(rand_illegal(), $urandom_range(0, 2), $urandom_range(0, 2), 1, 1'b0, -1);
          1: add_insn(rand_legal(), 0, $urandom_range(0, 2), $urandom_range(1, 6), 1'($urandom),
                      $urandom_range(0, 3));
          2: add_insn(rand_legal(), 0, 0, TMO + $urandom_range(0, 3), 1'b0, -1);
          default: add_insn(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(1, TMO - 1), 1'($urandom), -1);
        endcase
      end
    end
    run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
